// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite types, responder FSM encoding and byte-lane helper
package ahb_pkg;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3} htrans_t;
    typedef enum logic [1:0] {OKAY = 2'd0, ERROR = 2'd1, RETRY = 2'd2, SPLIT = 2'd3} hresp_t;
    typedef enum logic {READ = 1'b0, WRITE = 1'b1} hwrite_t;
    typedef enum logic [2:0] {
        BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2, SZ64 = 3'd3,
        SZ128 = 3'd4, SZ256 = 3'd5, SZ512 = 3'd6, SZ1024 = 3'd7
    } hsize_t;
    typedef enum logic [2:0] {
        SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
        WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
    } hburst_t;

    typedef logic [2:0] slv_state_t;
    localparam slv_state_t S_IDLE = 3'd0;
    localparam slv_state_t S_WAIT = 3'd1;
    localparam slv_state_t S_DATA = 3'd2;
    localparam slv_state_t S_ERR1 = 3'd3;
    localparam slv_state_t S_ERR2 = 3'd4;

    // Little-endian byte enables; only called for sizes already checked legal.
    function automatic logic [3:0] ahb_lane_mask(hsize_t size, logic [1:0] addr);
        case (size)
            BYTE:    return 4'b0001 << addr;
            HALF:    return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite bus bundle with master and slave views
interface ahb_bus;
    import ahb_pkg::*;

    logic        hsel;
    logic [31:0] haddr;
    hwrite_t     hwrite;
    htrans_t     htrans;
    hsize_t      hsize;
    hburst_t     hburst;
    logic [31:0] hwdata;
    logic        hready;
    hresp_t      hresp;
    logic [31:0] hrdata;
    logic [1:0]  hsplit;

    modport master (
        output hsel, haddr, hwrite, htrans, hsize, hburst, hwdata,
        input  hready, hresp, hrdata, hsplit
    );

    modport slave (
        input  hsel, haddr, hwrite, htrans, hsize, hburst, hwdata,
        output hready, hresp, hrdata, hsplit
    );
endinterface

// File: rtl/ahb_sram_bytelane.sv
// rtl/ahb_sram_bytelane.sv - word-wide SRAM with per-byte write enable and async read
module ahb_sram_bytelane #(
    parameter  int WORDS = 256,
    localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic           clk,
    input  logic [3:0]     we,
    input  logic [WAW-1:0] waddr,
    input  logic [31:0]    wdata,
    input  logic [WAW-1:0] raddr,
    output logic [31:0]    rdata
);
    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite SRAM responder with programmable wait states and ERROR response
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          MEM_BYTES   = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    ahb_bus.slave       bus,
    output logic [15:0] err_cnt
);
    localparam int         AW      = $clog2(MEM_BYTES);
    localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    slv_state_t    state_q, state_d;
    logic [3:0]    wcnt_q, wcnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    hsize_t        size_q;
    logic          acc, illegal;
    logic [3:0]    we;
    logic [31:0]   mem_rdata;
    logic          unused_burst;

    assign acc = bus.hsel && bus.hready && (bus.htrans == NONSEQ || bus.htrans == SEQ);

    assign illegal = (bus.haddr[31:AW] != ADDR_BASE[31:AW])
                  || (bus.hsize > WORD)
                  || (bus.hsize == HALF && bus.haddr[0])
                  || (bus.hsize == WORD && bus.haddr[1:0] != 2'b00);

    // IDLE, DATA and ERR2 all present hready=1, so each may take the next address phase.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_WAIT: begin
                if (wcnt_q == 4'd0) state_d = S_DATA;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (acc) begin
                    if (illegal)               state_d = S_ERR1;
                    else if (WAIT_STATES == 0) state_d = S_DATA;
                    else begin
                        state_d = S_WAIT;
                        wcnt_d  = WS_INIT;
                    end
                end
            end
        endcase
    end

    assign err_cnt_d = (state_q == S_ERR2 && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 4'd0;
            err_cnt_q <= 16'd0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            size_q    <= BYTE;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            err_cnt_q <= err_cnt_d;
            if (acc) begin
                addr_q <= bus.haddr[AW-1:0];
                wr_q   <= (bus.hwrite == WRITE);
                size_q <= bus.hsize;
            end
        end
    end

    // A reset landing on the completing cycle must not leave a partial write behind.
    assign we = (state_q == S_DATA && wr_q && !rst) ? ahb_lane_mask(size_q, addr_q[1:0]) : 4'b0000;

    ahb_sram_bytelane #(.WORDS(MEM_BYTES / 4)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (addr_q[AW-1:2]),
        .wdata (bus.hwdata),
        .raddr (addr_q[AW-1:2]),
        .rdata (mem_rdata)
    );

    assign bus.hready   = !(state_q == S_WAIT || state_q == S_ERR1);
    assign bus.hresp    = (state_q == S_ERR1 || state_q == S_ERR2) ? ERROR : OKAY;
    assign bus.hrdata   = (state_q == S_DATA && !wr_q) ? mem_rdata : 32'h0;
    assign bus.hsplit   = 2'b00;
    assign err_cnt      = err_cnt_q;
    assign unused_burst = ^bus.hburst;
endmodule
